// File: rtl/mmio_uart_tx_if.sv
// Core-side MMIO bus bundle for the UART transmitter: byte address, write data,
// combinational read data and single-cycle read/write strobes.
interface mmio_uart_tx_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        rd_en_i;
  logic        wr_en_i;

  modport master (output addr_i, data_i, rd_en_i, wr_en_i, input data_o);
  modport slave  (input addr_i, data_i, rd_en_i, wr_en_i, output data_o);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TXDATA/STATUS/CTRL registers.
// Define MMIO_UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              ovf_q;

  logic              hit;
  logic [1:0]        sel;
  logic              push_req;
  logic              ctrl_clr;
  logic              full;
  logic              empty;
  logic              pop;
  logic [7:0]        head;
  logic [CNT_FW-1:0] count;
  logic [31:0]       status;
  logic              unused_bits;

  assign hit      = bus.addr_i[31:4] == BASE_ADDR[31:4];
  assign sel      = bus.addr_i[3:2];
  assign push_req = bus.wr_en_i && hit && (sel == 2'd0);
  assign ctrl_clr = bus.wr_en_i && hit && (sel == 2'd2) && bus.data_i[0];
  assign pop      = (state_q == IDLE) && !empty;
  assign unused_bits = ^{bus.addr_i[1:0], bus.data_i[31:8]};

`ifdef MMIO_UART_TX_FIFO_EN
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_FW-1:0] count_q;
  logic [CNT_FW-1:0] count_d;

  assign full  = count_q == CNT_FW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign head  = mem_q[rptr_q];
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (push_req && !full) count_d = count_d + CNT_FW'(1);
    if (pop)               count_d = count_d - CNT_FW'(1);
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_req && !full) begin
        mem_q[wptr_q] <= bus.data_i[7:0];
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign full  = hold_vld_q;
  assign empty = !hold_vld_q;
  assign head  = hold_q;
  assign count = {{(CNT_FW-1){1'b0}}, hold_vld_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push_req && !full) begin
      hold_q     <= bus.data_i[7:0];
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  // A push against a full buffer is lost even if the transmitter pops this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                ovf_q <= 1'b0;
    else if (push_req && full) ovf_q <= 1'b1;
    else if (ctrl_clr)         ovf_q <= 1'b0;
  end

  assign status      = {17'd0, 7'(count), 4'd0, ovf_q, empty, full, state_q != IDLE};
  assign bus.data_o  = (bus.rd_en_i && hit && (sel == 2'd1)) ? status : 32'd0;
  assign uart_tx_o   = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= head;
            cnt_q   <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: random MMIO bursts feed a byte-level model,
// a line monitor decodes each frame and compares it with the queued expectation.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
`ifdef MMIO_UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rst_count = 0;
  bit   mon_en = 1'b0;
  bit   mon_busy = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] bb[16];
  bit         vv[16];

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR (32'h0000_1000),
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .uart_tx_o(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int occ, input bit busy, input bit ovf);
    logic [31:0] s;
    s = 32'(occ) << 8;
    s[3] = ovf;
    s[2] = (occ == 0);
    s[1] = (occ == DEPTH);
    s[0] = busy;
    return s;
  endfunction

  function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
    logic [9:0] bits;
    logic [FRAME-1:0] w;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a; bus.data_i = d; bus.wr_en_i = 1'b1; bus.rd_en_i = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.wr_en_i = 1'b0; bus.addr_i = a; bus.rd_en_i = 1'b1;
    #1 d = bus.data_o;
    bus.rd_en_i = 1'b0;
  endtask

  // One contiguous burst of n writes described by bb/vv, then register checks and drain.
  task automatic burst(input int n);
    int occ; bit sent; bit ovf; bit first; bit pushed; int budget;
    logic [31:0] d; logic [31:0] r;
    occ = 0; sent = 0; ovf = 0; first = 1;
    for (int j = 0; j < n; j++) begin
      pushed = 0;
      r = $urandom();
      if (vv[j]) begin
        wr(32'h0000_1000, {r[31:8], bb[j]});
        if (occ == DEPTH) ovf = 1;
        else begin
          exp_q.push_back({~first, bb[j]});
          first = 0;
          pushed = 1;
        end
      end else begin
        wr(32'h0000_2000, {r[31:8], bb[j]});
      end
      if (occ > 0 && !sent) begin occ--; sent = 1; end
      if (pushed) occ++;
    end
    idle();
    if (occ > 0 && !sent) begin occ--; sent = 1; end
    rd(32'h0000_1004, d); check("status_after_burst", d, st(occ, sent, ovf));
    wr(32'h0000_1008, 32'hFFFF_FFFE);
    rd(32'h0000_1004, d); check("status_ctrl_bit0_clear", d, st(occ, sent, ovf));
    wr(32'h0000_100C, $urandom());
    wr(32'h0000_1008, 32'h0000_0001);
    rd(32'h0000_1004, d); check("status_after_ovf_clear", d, st(occ, sent, 1'b0));
    rd(32'h0000_1000, d); check("read_txdata_zero", d, 32'd0);
    rd(32'h0000_1008, d); check("read_ctrl_zero", d, 32'd0);
    rd(32'h0000_100C, d); check("read_reserved_zero", d, 32'd0);
    rd(32'h0000_2004, d); check("read_miss_zero", d, 32'd0);
    budget = (DEPTH + 2) * (FRAME + 1) + 50;
    while ((exp_q.size() > 0 || mon_busy) && budget > 0) begin
      idle();
      budget--;
    end
    check("frames_drained", exp_q.size(), 0);
    repeat (3) idle();
    rd(32'h0000_1004, d); check("status_idle_after_drain", d, 32'h0000_0004);
  endtask

  initial begin : monitor
    logic prev;
    logic [FRAME-1:0] wave;
    logic [8:0] e;
    int rc;
    int start_cyc;
    int last_start;
    prev = 1'b1;
    last_start = -1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !tx) begin
        mon_busy = 1;
        rc = rst_count;
        start_cyc = cyc;
        wave = '0;
        wave[0] = tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          wave[i] = tx;
        end
        if (rc == rst_count) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got frame bits %0h expected no frame", wave);
          end else begin
            e = exp_q.pop_front();
            check("frame_wave", wave, exp_wave(e[7:0]));
            if (last_start >= 0) check("start_gap_min", (start_cyc - last_start) >= FRAME + 1, 1'b1);
            if (e[8]) check("start_gap_back_to_back", start_cyc - last_start, FRAME + 1);
          end
          last_start = start_cyc;
        end else begin
          last_start = -1;
        end
        mon_busy = 0;
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    bus.addr_i = '0; bus.data_i = '0; bus.rd_en_i = 1'b0; bus.wr_en_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("line_idle_after_reset", tx, 1'b1);
    mon_en = 1'b1;
    rd(32'h0000_1004, d); check("status_reset", d, 32'h0000_0004);
    @(negedge clk);
    bus.addr_i = 32'h0000_1004; bus.rd_en_i = 1'b0;
    #1 check("data_o_zero_without_rd", bus.data_o, 32'd0);

    bb[0] = 8'hA5; vv[0] = 1;
    burst(1);
    bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h03;
    for (int j = 0; j < 3; j++) vv[j] = 1;
    burst(3);
    for (int j = 0; j < 10; j++) begin bb[j] = 8'(j * 17 + 3); vv[j] = 1; end
    burst(10);
    for (int j = 0; j < 2; j++) begin bb[j] = 8'($urandom()); vv[j] = 0; end
    burst(2);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 11);
      for (int j = 0; j < n; j++) begin
        bb[j] = 8'($urandom());
        vv[j] = ($urandom_range(0, 7) != 0);
      end
      burst(n);
    end

    // Reset in the middle of DATA bit 3 with two more bytes queued behind it.
    wr(32'h0000_1000, 32'h0000_00F0);
    wr(32'h0000_1000, 32'h0000_0011);
    wr(32'h0000_1000, 32'h0000_0022);
    repeat (43) idle();
    @(negedge clk);
    check("line_low_in_bit3", tx, 1'b0);
    rst_n = 1'b0;
    rst_count++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("line_high_after_midframe_reset", tx, 1'b1);
    rd(32'h0000_1004, d); check("status_after_midframe_reset", d, 32'h0000_0004);
    repeat (300) idle();
    check("line_idle_after_reset_wait", tx, 1'b1);
    rd(32'h0000_1004, d); check("status_final", d, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, base of the 16-byte register window.
REQ-002 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, must be >=2).
REQ-004 Parameter FIFO_DEPTH, default 8, TX FIFO entries, power of two, 2..64.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 addr_i  input  32  byte address from core memory port.
REQ-008 data_i  input  32  write data from core.
REQ-009 data_o  output  32  read data to core, combinational.
REQ-010 rd_en_i  input  1  read strobe.
REQ-011 wr_en_i  input  1  write strobe, one-cycle pulse per store.
REQ-012 uart_tx_o  output  1  serial line, idle high.

Function
REQ-013 Hit = addr_i[31:4] == BASE_ADDR[31:4]; register select = addr_i[3:2]; accesses without hit have no effect, data_o = 0.
REQ-014 Offset 0x0 TXDATA: write with hit pushes data_i[7:0] into FIFO; reads return 0.
REQ-015 Offset 0x4 STATUS (read-only): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[14:8] FIFO count, other bits 0.
REQ-016 Offset 0x8 CTRL: write with data_i[0]=1 clears overflow; reads return 0; offset 0xC reserved, reads 0, writes ignored.
REQ-017 data_o is valid in the same cycle as rd_en_i (zero wait states); data_o = 0 when rd_en_i is low.
REQ-018 Push while full (full as registered at cycle start) is dropped and sets overflow, even if a pop occurs that cycle.
REQ-019 Push and pop in the same cycle when not full and not empty: both occur, count unchanged.
REQ-020 FSM states IDLE, START, DATA, STOP; uart_tx_o = 1 in IDLE and STOP, 0 in START, shift[0] in DATA.
REQ-021 IDLE with FIFO non-empty: pop head into shift register, go START next cycle; the pop cycle itself drives line high.
REQ-022 START, each DATA bit and STOP each last exactly CLKS_PER_BIT cycles, counted by a bit-period counter reset on every state/bit change.
REQ-023 DATA sends 8 bits LSB first, shift right after each bit period; after bit 7 go STOP.
REQ-024 STOP end returns to IDLE; minimum spacing between consecutive start-bit falling edges is 10*CLKS_PER_BIT+1 cycles.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 Writes to TXDATA during an active frame do not disturb the frame in progress.

Reset
REQ-027 On rst_n low at a rising edge: FSM IDLE, FIFO empty (pointers, count 0), overflow 0, bit counters 0, shift register 0, uart_tx_o 1.
REQ-028 Reset mid-frame aborts the frame immediately; line is high the cycle after the reset edge; queued bytes are discarded.
REQ-029 data_o depends only on inputs and registered state; after reset a STATUS read returns 32'h0000_0004.

Configuration
REQ-030 Macro MMIO_UART_TX_FIFO_EN defined: FIFO of FIFO_DEPTH entries as above.
REQ-031 Macro undefined: single holding register replaces FIFO (effective depth 1); full = holding valid, count bits are 0 or 1; all other behaviour unchanged.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10, BASE_ADDR=32'h1000, FIFO enabled)
REQ-032 Write 32'h0000_00A5 to 0x1000 -> line low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles; busy=1 throughout.
REQ-033 Write bytes 0x01,0x02,0x03 back-to-back -> three frames in order, start edges 101 cycles apart; STATUS count reads 2 just after the first pop.
REQ-034 Nine writes with line busy -> eight queued, STATUS full=1, overflow=1; CLTR write 1 to 0x1008 -> overflow=0, full unchanged.
REQ-035 Read 0x1004 after reset -> data_o = 32'h0000_0004 same cycle; read 0x2004 -> data_o = 0; write 0x2000 -> no frame.
REQ-036 Assert rst_n low during DATA bit 3 -> uart_tx_o=1 next cycle, STATUS = 32'h0000_0004, no further frames.
REQ-037 Rebuild without MMIO_UART_TX_FIFO_EN, write two bytes while busy -> second accepted only if holding empty, else overflow=1.
